// File: rtl/host_sdram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : host_sdram_bridge_if
// Description : Bundles the host memory port and the 16-bit toggle req/ack
//               SDRAM controller port of host_sdram_bridge.
//               slave  - seen by the bridge
//               master - seen by the host/controller environment
// Ports       : host_valid/addr/wdata/wstrb -> bridge, host_ready/rdata <-
//               mem_addr/req/ds/din/we <- bridge, mem_req_ack/dout -> bridge
// Revision    : 1.0 - initial release
// ============================================================================
interface host_sdram_bridge_if #(
    parameter int HOST_W = 32,
    parameter int ADDR_W = 23
) ();
    logic                  host_valid;
    logic [ADDR_W-1:0]     host_addr;
    logic [HOST_W-1:0]     host_wdata;
    logic [HOST_W/8-1:0]   host_wstrb;
    logic                  host_ready;
    logic [HOST_W-1:0]     host_rdata;
    logic [ADDR_W-2:0]     mem_addr;
    logic                  mem_req;
    logic [1:0]            mem_ds;
    logic [15:0]           mem_din;
    logic                  mem_we;
    logic                  mem_req_ack;
    logic [15:0]           mem_dout;

    modport slave (
        input  host_valid, host_addr, host_wdata, host_wstrb, mem_req_ack, mem_dout,
        output host_ready, host_rdata, mem_addr, mem_req, mem_ds, mem_din, mem_we
    );

    modport master (
        output host_valid, host_addr, host_wdata, host_wstrb, mem_req_ack, mem_dout,
        input  host_ready, host_rdata, mem_addr, mem_req, mem_ds, mem_din, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/host_sdram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : host_sdram_bridge
// Description : Bridges a HOST_W-bit host memory port onto a 16-bit toggle
//               req/ack SDRAM controller port. Each host access is split into
//               sequential 16-bit beats; write beats with all-zero byte
//               strobes are skipped. Reads always fetch every beat.
//               Optional macro WRITE_POST_EN: writes are acknowledged to the
//               host immediately and drain in the background.
// Ports       : clk, resetn (synchronous, active-low)
//               bus (host_sdram_bridge_if.slave) - host and controller ports
// Revision    : 1.0 - initial release
// ============================================================================
module host_sdram_bridge #(
    parameter int HOST_W = 32,
    parameter int ADDR_W = 23
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    host_sdram_bridge_if.slave bus
);
    localparam int c_BEATS = HOST_W / 16;
    localparam int c_IDX_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_SW    = HOST_W / 8;
    // Word-address bits replaced by the beat index.
    localparam logic [ADDR_W-2:0] c_MASK = (ADDR_W-1)'(c_BEATS - 1);

    // A beat is issued on the transition into S_WAIT, so the request toggle
    // becomes visible the cycle after the decision; there is no separate
    // issue cycle, which keeps every beat at (ack delay + 1) cycles.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Lowest beat index >= from that must be transferred; MSB = found.
    function automatic logic [c_IDX_W:0] pick_beat(input logic [c_SW-1:0] strb,
                                                   input logic rd, input int from);
        logic [c_IDX_W:0] res;
        res = '0;
        for (int j = c_BEATS - 1; j >= 0; j--) begin
            if (j >= from && (rd || strb[2*j +: 2] != 2'b00))
                res = {1'b1, c_IDX_W'(j)};
        end
        return res;
    endfunction

    state_t              r_state, w_state_n;
    logic [ADDR_W-2:0]   r_base;
    logic [HOST_W-1:0]   r_wdata;
    logic [c_SW-1:0]     r_wstrb;
    logic                r_rd;
    logic [c_IDX_W-1:0]  r_idx;
    logic [ADDR_W-2:0]   r_mem_addr;
    logic                r_req;
    logic [1:0]          r_ds;
    logic [15:0]         r_din;
    logic                r_we;
    logic                r_ready;
    logic [HOST_W-1:0]   r_rdata;

    logic                w_is_rd_in, w_acked, w_accept, w_issue, w_capture, w_ready_n;
    logic                w_posted;
    logic [c_IDX_W:0]    w_first, w_next;
    logic [ADDR_W-2:0]   w_src_base;
    logic [HOST_W-1:0]   w_src_wdata;
    logic [c_SW-1:0]     w_src_strb;
    logic                w_src_rd;
    logic [c_IDX_W-1:0]  w_src_idx;
    logic                w_unused;

    assign w_unused = &{1'b0, bus.host_addr[0]};

    always_comb begin
        w_state_n  = r_state;
        w_accept   = 1'b0;
        w_issue    = 1'b0;
        w_capture  = 1'b0;
        w_ready_n  = 1'b0;
        w_is_rd_in = (bus.host_wstrb == '0);
        w_acked    = (bus.mem_req_ack == r_req);
        w_first    = pick_beat(bus.host_wstrb, w_is_rd_in, 0);
        w_next     = pick_beat(r_wstrb, r_rd, int'(r_idx) + 1);

        case (r_state)
            S_IDLE: begin
                if (bus.host_valid) begin
                    w_accept  = 1'b1;
                    w_issue   = 1'b1;
                    w_state_n = S_WAIT;
`ifdef WRITE_POST_EN
                    w_ready_n = !w_is_rd_in;
`endif
                end
            end
            S_WAIT: begin
                if (w_acked) begin
                    w_capture = r_rd;
                    if (w_next[c_IDX_W]) begin
                        w_issue = 1'b1;
                    end else if (w_posted) begin
                        // Host already released at accept; go straight back.
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n = S_DONE;
                        w_ready_n = 1'b1;
                    end
                end
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase

        // First beat comes from the live host inputs, later beats from the
        // latched copy (host inputs may change after accept).
        if (w_accept) begin
            w_src_base  = bus.host_addr[ADDR_W-1:1] & ~c_MASK;
            w_src_wdata = bus.host_wdata;
            w_src_strb  = bus.host_wstrb;
            w_src_rd    = w_is_rd_in;
            w_src_idx   = w_first[c_IDX_W-1:0];
        end else begin
            w_src_base  = r_base;
            w_src_wdata = r_wdata;
            w_src_strb  = r_wstrb;
            w_src_rd    = r_rd;
            w_src_idx   = w_next[c_IDX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rd       <= 1'b0;
            r_idx      <= '0;
            r_mem_addr <= '0;
            r_req      <= 1'b0;
            r_ds       <= 2'b00;
            r_din      <= '0;
            r_we       <= 1'b0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_n;
            r_ready <= w_ready_n;
            if (w_accept) begin
                r_base  <= w_src_base;
                r_wdata <= bus.host_wdata;
                r_wstrb <= bus.host_wstrb;
                r_rd    <= w_is_rd_in;
            end
            if (w_issue) begin
                r_idx      <= w_src_idx;
                r_mem_addr <= w_src_base | (ADDR_W-1)'(w_src_idx);
                r_ds       <= w_src_rd ? 2'b11 : w_src_strb[2*w_src_idx +: 2];
                r_din      <= w_src_wdata[16*w_src_idx +: 16];
                r_we       <= !w_src_rd;
                r_req      <= !r_req;
            end
            if (w_capture)
                r_rdata[16*r_idx +: 16] <= bus.mem_dout;
        end
    end

`ifdef WRITE_POST_EN
    logic r_posted;
    always_ff @(posedge clk) begin
        if (!resetn)
            r_posted <= 1'b0;
        else if (w_accept)
            r_posted <= !w_is_rd_in;
    end
    assign w_posted = r_posted;
`else
    assign w_posted = 1'b0;
`endif

    assign bus.host_ready = r_ready;
    assign bus.host_rdata = r_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_req    = r_req;
    assign bus.mem_ds     = r_ds;
    assign bus.mem_din    = r_din;
    assign bus.mem_we     = r_we;
endmodule
`default_nettype wire

// File: tb/tb_host_sdram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_sdram_bridge
// Description : Self-checking bench for host_sdram_bridge (HOST_W=32) with a
//               toggle req/ack controller model, a word-array memory
//               reference and randomized accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_sdram_bridge;
    localparam int HW = 32;
    localparam int AW = 23;
    localparam int NB = HW / 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    host_sdram_bridge_if #(.HOST_W(HW), .ADDR_W(AW)) bus ();
    host_sdram_bridge #(.HOST_W(HW), .ADDR_W(AW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct {
        logic [21:0] addr;
        logic [1:0]  ds;
        logic [15:0] din;
        logic        we;
    } beat_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // ---------------- controller model ----------------
    logic [15:0] ctrl_mem [0:255];
    logic        ctrl_init = 1'b0;
    logic        ack_r = 1'b0;
    int          ack_cnt = 0;
    int          ctrl_delay = 0;
    int          last_wr_ack_cyc = 0;
    logic        prev_req = 1'b0;
    int          overlap_err = 0;
    beat_t       log_q[$];

    assign bus.mem_req_ack = (bus.mem_req != ack_r && ack_cnt >= ctrl_delay) ? bus.mem_req : ack_r;
    assign bus.mem_dout    = ctrl_mem[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        beat_t b;
        cyc <= cyc + 1;
        if (!resetn) begin
            ack_r    <= 1'b0;
            ack_cnt  <= 0;
            prev_req <= 1'b0;
            if (!ctrl_init) begin
                for (int i = 0; i < 256; i++) ctrl_mem[i] <= 16'(i * 40503 + 4660);
                ctrl_init <= 1'b1;
            end
        end else begin
            if (bus.mem_req != prev_req) begin
                b.addr = bus.mem_addr; b.ds = bus.mem_ds; b.din = bus.mem_din; b.we = bus.mem_we;
                log_q.push_back(b);
                if (ack_r != prev_req) overlap_err <= overlap_err + 1;
            end
            prev_req <= bus.mem_req;
            if (bus.mem_req != ack_r) begin
                if (ack_cnt >= ctrl_delay) begin
                    ack_r   <= bus.mem_req;
                    ack_cnt <= 0;
                    if (bus.mem_we) begin
                        if (bus.mem_ds[0]) ctrl_mem[bus.mem_addr[7:0]][7:0]  <= bus.mem_din[7:0];
                        if (bus.mem_ds[1]) ctrl_mem[bus.mem_addr[7:0]][15:8] <= bus.mem_din[15:8];
                        last_wr_ack_cyc <= cyc;
                    end
                end else begin
                    ack_cnt <= ack_cnt + 1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [0:255];
    logic [31:0] exp_rdata = '0;
    beat_t       exp_q[$];

    function automatic void model_plan(input logic [22:0] a, input logic [31:0] wd, input logic [3:0] ws);
        beat_t b;
        exp_q.delete();
        for (int i = 0; i < NB; i++) begin
            logic [1:0] pair;
            pair = ws[2*i +: 2];
            if (ws == 4'b0000 || pair != 2'b00) begin
                b.addr = 22'((a / 4) * 2 + i);
                b.ds   = (ws == 4'b0000) ? 2'b11 : pair;
                b.din  = wd[16*i +: 16];
                b.we   = (ws != 4'b0000);
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic void model_write(input logic [22:0] a, input logic [31:0] wd, input logic [3:0] ws);
        for (int byt = 0; byt < 4; byt++) begin
            int w;
            w = (a / 4) * 2 + byt / 2;
            if (ws[byt]) begin
                if (byt % 2 == 0) ref_mem[w][7:0]  = wd[8*byt +: 8];
                else              ref_mem[w][15:8] = wd[8*byt +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [22:0] a);
        int w;
        w = (a / 4) * 2;
        return {ref_mem[w+1], ref_mem[w]};
    endfunction

    function automatic int model_lat(input logic [3:0] ws, input int n, input int dly);
`ifdef WRITE_POST_EN
        if (ws != 4'b0000) return 1;
`endif
        return 1 + n * (dly + 1);
    endfunction

    // ---------------- drivers ----------------
    task automatic do_access(input logic [22:0] a, input logic [31:0] wd, input logic [3:0] ws,
                             output int lat, output logic [31:0] rd);
        @(negedge clk);
        bus.host_valid = 1'b1;
        bus.host_addr  = a;
        bus.host_wdata = wd;
        bus.host_wstrb = ws;
        @(posedge clk);
        #1;
        bus.host_valid = 1'b0;
        bus.host_addr  = 23'($urandom);
        bus.host_wdata = $urandom;
        bus.host_wstrb = 4'($urandom);
        lat = -1;
        rd  = 'x;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (bus.host_ready === 1'b1) begin
                lat = c;
                rd  = bus.host_rdata;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int n, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (log_q.size() >= n && bus.mem_req_ack === bus.mem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        resetn = 1'b0;
        bus.host_valid = 1'b0; bus.host_addr = '0; bus.host_wdata = '0; bus.host_wstrb = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.host_ready, bus.mem_req, bus.mem_we} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctl: ready/req/we=%b want 000", {bus.host_ready, bus.mem_req, bus.mem_we});
        end
        n_cmp++;
        if (bus.host_rdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.host_rdata);
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_ds, bus.mem_din} !== '0) begin
            n_bad++; $display("FAIL reset_mem: addr=%h ds=%b din=%h want 0", bus.mem_addr, bus.mem_ds, bus.mem_din);
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 40503 + 4660);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_spec_read;
        int lat; logic [31:0] rd; logic ok;
        // Seed words 0x80/0x81 with BEEF/DEAD through the bridge itself.
        ctrl_delay = 1;
        log_q.delete();
        do_access(23'h000100, 32'hDEADBEEF, 4'hF, lat, rd);
        model_write(23'h000100, 32'hDEADBEEF, 4'hF);
        wait_drain(2, ok);
        ctrl_delay = 3;
        log_q.delete();
        do_access(23'h000100, 32'h0, 4'h0, lat, rd);
        n_cmp++;
        if (lat !== 9) begin n_bad++; $display("FAIL spec_read_lat: got %0d want 9", lat); end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL spec_read_data: got %h want deadbeef", rd); end
        n_cmp++;
        if (log_q.size() !== 2 || log_q[0].addr !== 22'h80 || log_q[1].addr !== 22'h81) begin
            n_bad++; $display("FAIL spec_read_addr: beats=%0d first=%h want 2 beats 80,81", log_q.size(),
                              (log_q.size() > 0) ? log_q[0].addr : 22'h0);
        end
        exp_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_sparse_write;
        int lat; logic [31:0] rd; logic ok;
        ctrl_delay = 2;
        log_q.delete();
        do_access(23'h000040, 32'h00AA0000, 4'b0100, lat, rd);
        model_write(23'h000040, 32'h00AA0000, 4'b0100);
        wait_drain(1, ok);
        @(negedge clk);
        n_cmp++;
        if (log_q.size() !== 1) begin
            n_bad++; $display("FAIL sparse_count: got %0d beats want 1", log_q.size());
        end else begin
            n_cmp++;
            if (log_q[0].addr !== 22'h21 || log_q[0].ds !== 2'b01 || log_q[0].din !== 16'h00AA || log_q[0].we !== 1'b1) begin
                n_bad++; $display("FAIL sparse_beat: addr=%h ds=%b din=%h we=%b want 21/01/00aa/1",
                                  log_q[0].addr, log_q[0].ds, log_q[0].din, log_q[0].we);
            end
        end
        n_cmp++;
        if (lat !== model_lat(4'b0100, 1, 2)) begin
            n_bad++; $display("FAIL sparse_lat: got %0d want %0d", lat, model_lat(4'b0100, 1, 2));
        end
    endtask

    task automatic test_ack_zero;
        int lat; logic [31:0] rd;
        ctrl_delay = 0;
        log_q.delete();
        do_access(23'h000040, 32'h0, 4'h0, lat, rd);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL ack0_lat: got %0d want 3", lat); end
        n_cmp++;
        if (rd !== model_read(23'h000040)) begin
            n_bad++; $display("FAIL ack0_data: got %h want %h", rd, model_read(23'h000040));
        end
        exp_rdata = model_read(23'h000040);
    endtask

    task automatic test_reset_midflight;
        int lat; logic [31:0] rd; logic seen;
        ctrl_delay = 6;
        @(negedge clk);
        bus.host_valid = 1'b1; bus.host_addr = 23'h000020; bus.host_wstrb = 4'h0;
        @(negedge clk);
        bus.host_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.host_ready, bus.mem_req, bus.mem_we, bus.mem_ds, bus.mem_addr, bus.mem_din, bus.host_rdata} !== '0) begin
            n_bad++; $display("FAIL midreset_outputs: req=%b we=%b addr=%h rdata=%h want all 0",
                              bus.mem_req, bus.mem_we, bus.mem_addr, bus.host_rdata);
        end
        @(negedge clk);
        resetn = 1'b1;
        exp_rdata = '0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.host_ready === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_ready: got ready pulse want none"); end
        ctrl_delay = 1;
        log_q.delete();
        do_access(23'h000024, 32'h0, 4'h0, lat, rd);
        n_cmp++;
        if (lat !== 5 || rd !== model_read(23'h000024)) begin
            n_bad++; $display("FAIL midreset_next: lat=%0d data=%h want 5 %h", lat, rd, model_read(23'h000024));
        end
        exp_rdata = model_read(23'h000024);
    endtask

`ifdef WRITE_POST_EN
    task automatic test_posted;
        int lat; logic [31:0] rd; logic [31:0] wd; logic req_seen; int read_tog;
        ctrl_delay = 3;
        wd = $urandom;
        log_q.delete();
        do_access(23'h000180, wd, 4'hF, lat, rd);
        model_write(23'h000180, wd, 4'hF);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL posted_lat: got %0d want 1", lat); end
        bus.host_valid = 1'b1; bus.host_addr = 23'h000180; bus.host_wstrb = 4'h0;
        req_seen = bus.mem_req;
        read_tog = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.mem_we === 1'b0 && bus.mem_req !== req_seen) begin read_tog = cyc; break; end
            req_seen = bus.mem_req;
        end
        bus.host_valid = 1'b0;
        n_cmp++;
        if (read_tog <= last_wr_ack_cyc) begin
            n_bad++; $display("FAIL posted_order: read toggle cycle %0d want after write ack %0d", read_tog, last_wr_ack_cyc);
        end
        rd = 'x;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.host_ready === 1'b1) begin rd = bus.host_rdata; break; end
        end
        n_cmp++;
        if (rd !== wd) begin n_bad++; $display("FAIL posted_readback: got %h want %h", rd, wd); end
        exp_rdata = wd;
    endtask
`endif

    task automatic test_random;
        int lat; logic [31:0] rd; logic ok; logic [22:0] a; logic [31:0] wd; logic [3:0] ws;
        for (int it = 0; it < 40; it++) begin
            a  = 23'(($urandom_range(0, 127) * 4) | $urandom_range(0, 3));
            wd = $urandom;
            ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ctrl_delay = $urandom_range(0, 4);
            model_plan(a, wd, ws);
            log_q.delete();
            do_access(a, wd, ws, lat, rd);
            n_cmp++;
            if (lat !== model_lat(ws, exp_q.size(), ctrl_delay)) begin
                n_bad++; $display("FAIL rand_lat[%0d]: got %0d want %0d", it, lat, model_lat(ws, exp_q.size(), ctrl_delay));
            end
            if (ws == 4'h0) begin
                exp_rdata = model_read(a);
                n_cmp++;
                if (rd !== exp_rdata) begin n_bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", it, rd, exp_rdata); end
            end else begin
                model_write(a, wd, ws);
                n_cmp++;
                if (rd !== exp_rdata) begin n_bad++; $display("FAIL rand_rdata_hold[%0d]: got %h want %h", it, rd, exp_rdata); end
            end
            @(negedge clk);
            n_cmp++;
            if (bus.host_ready !== 1'b0) begin n_bad++; $display("FAIL rand_pulse[%0d]: ready=%b want 0", it, bus.host_ready); end
            wait_drain(exp_q.size(), ok);
            n_cmp++;
            if (!ok || log_q.size() !== exp_q.size()) begin
                n_bad++; $display("FAIL rand_beats[%0d]: got %0d beats want %0d", it, log_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_cmp++;
                    if (log_q[i].addr !== exp_q[i].addr || log_q[i].ds !== exp_q[i].ds || log_q[i].we !== exp_q[i].we ||
                        (exp_q[i].we && log_q[i].din !== exp_q[i].din)) begin
                        n_bad++; $display("FAIL rand_beat[%0d.%0d]: got %h/%b/%h/%b want %h/%b/%h/%b", it, i,
                                          log_q[i].addr, log_q[i].ds, log_q[i].din, log_q[i].we,
                                          exp_q[i].addr, exp_q[i].ds, exp_q[i].din, exp_q[i].we);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2; logic [31:0] rd1, rd2;
        ctrl_delay = 0;
        do_access(23'h000008, 32'h0, 4'h0, lat1, rd1);
        do_access(23'h00000C, 32'h0, 4'h0, lat2, rd2);
        n_cmp++;
        if (lat1 !== 3 || lat2 !== 3) begin n_bad++; $display("FAIL b2b_lat: got %0d,%0d want 3,3", lat1, lat2); end
        n_cmp++;
        if (rd1 !== model_read(23'h000008) || rd2 !== model_read(23'h00000C)) begin
            n_bad++; $display("FAIL b2b_data: got %h,%h want %h,%h", rd1, rd2, model_read(23'h000008), model_read(23'h00000C));
        end
        exp_rdata = model_read(23'h00000C);
    endtask

    task automatic test_protocol;
        n_cmp++;
        if (overlap_err !== 0) begin n_bad++; $display("FAIL one_outstanding: got %0d overlaps want 0", overlap_err); end
    endtask

    initial begin
        test_reset();
        test_spec_read();
        test_sparse_write();
        test_ack_zero();
        test_back_to_back();
        test_random();
`ifdef WRITE_POST_EN
        test_posted();
`endif
        test_reset_midflight();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
